// File: rtl/eth_gen_pkg.sv
// Shared constants for the Ethernet test-frame generator: FSM states,
// length defaults, header layout and the last-beat keep mask.
package eth_gen_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_GAP  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam int          MIN_LEN_DEF   = 60;
  localparam int          MAX_LEN_DEF   = 9600;
  localparam logic [15:0] ETHERTYPE_DEF = 16'h88B5;

  // Byte offsets of the header fields within a frame
  localparam logic [13:0] OFS_DST  = 14'd0;
  localparam logic [13:0] OFS_SRC  = 14'd6;
  localparam logic [13:0] OFS_TYPE = 14'd12;
  localparam logic [13:0] OFS_SEQ  = 14'd14;
  localparam logic [13:0] OFS_PAY  = 14'd18;

  function automatic logic [7:0] keep_mask(input logic [2:0] rem);
    keep_mask = (rem == 3'd0) ? 8'hFF : 8'((9'd1 << rem) - 9'd1);
  endfunction

endpackage

// File: rtl/eth_gen_beat_builder.sv
// Combinational beat formatter: turns a beat index plus the latched frame
// parameters into one 64-bit AXI-Stream beat (tdata/tkeep/tlast).
module eth_gen_beat_builder
  import eth_gen_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE = ETHERTYPE_DEF
) (
  input  logic [10:0] i_beat,
  input  logic [47:0] i_dst_mac,
  input  logic [47:0] i_src_mac,
  input  logic [31:0] i_seq,
  input  logic [13:0] i_len,
  output logic [63:0] o_tdata,
  output logic [7:0]  o_tkeep,
  output logic        o_tlast
);

  logic [13:0] w_len_m1;
  logic [10:0] w_last_beat;

  assign w_len_m1    = i_len - 14'd1;
  assign w_last_beat = w_len_m1[13:3];
  assign o_tlast     = (i_beat == w_last_beat);
  assign o_tkeep     = o_tlast ? keep_mask(i_len[2:0]) : 8'hFF;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    logic [13:0] w_n;
    logic [13:0] w_si;
    logic [13:0] w_qi;
    logic [7:0]  w_byte;

    assign w_n  = {i_beat, 3'(k)};
    assign w_si = w_n - OFS_SRC;
    assign w_qi = w_n - OFS_SEQ;

    // Multi-byte fields go out MSB first, so the shift counts down from the top byte
    always_comb begin
      w_byte = w_n[7:0];
      if (w_n < OFS_SRC)
        w_byte = 8'(i_dst_mac >> {3'd5 - w_n[2:0], 3'b000});
      else if (w_n < OFS_TYPE)
        w_byte = 8'(i_src_mac >> {3'd5 - w_si[2:0], 3'b000});
      else if (w_n < OFS_SEQ)
        w_byte = w_n[0] ? ETHERTYPE[7:0] : ETHERTYPE[15:8];
      else if (w_n < OFS_PAY)
        w_byte = 8'(i_seq >> {2'd3 - w_qi[1:0], 3'b000});
    end

    assign o_tdata[8*k +: 8] = o_tkeep[k] ? w_byte : 8'h00;
  end

endmodule

// File: rtl/eth_frame_gen.sv
// Ethernet test-frame generator: FSM, counters and registered AXI-Stream
// master; beat contents come from eth_gen_beat_builder.
module eth_frame_gen
  import eth_gen_pkg::*;
#(
  parameter int          MIN_LEN   = MIN_LEN_DEF,
  parameter int          MAX_LEN   = MAX_LEN_DEF,
  parameter logic [15:0] ETHERTYPE = ETHERTYPE_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [13:0] i_frame_len,
  input  logic [7:0]  i_ifg_cycles,
  input  logic [31:0] i_frame_count,
  input  logic [47:0] i_dst_mac,
  input  logic [47:0] i_src_mac,
  output logic        o_m_axis_tvalid,
  input  logic        i_m_axis_tready,
  output logic [63:0] o_m_axis_tdata,
  output logic [7:0]  o_m_axis_tkeep,
  output logic        o_m_axis_tlast,
  output logic [0:0]  o_m_axis_tuser,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_frames_sent
);

  localparam logic [13:0] LEN_LO = 14'(MIN_LEN);
  localparam logic [13:0] LEN_HI = 14'(MAX_LEN);

  state_t      r_state;
  logic [10:0] r_beat;
  logic [13:0] r_len;
  logic [7:0]  r_ifg;
  logic [7:0]  r_gap_cnt;
  logic [47:0] r_dst;
  logic [47:0] r_src;
  logic [31:0] r_fc;
  logic [31:0] r_frames_sent;
  logic        r_tvalid;
  logic        r_tlast;
  logic [7:0]  r_tkeep;
  logic [63:0] r_tdata;

  logic [13:0] w_len_clamp;
  logic        w_accept, w_last_acc, w_run_done;
  logic        w_idle_start, w_b2b, w_gap_start, w_start, w_next_beat;
  logic [31:0] w_sent_inc, w_seq_start;
  logic [10:0] w_bld_beat;
  logic [47:0] w_bld_dst, w_bld_src;
  logic [31:0] w_bld_seq;
  logic [13:0] w_bld_len;
  logic [63:0] w_tdata;
  logic [7:0]  w_tkeep;
  logic        w_tlast;

  assign w_len_clamp = (i_frame_len < LEN_LO) ? LEN_LO :
                       (i_frame_len > LEN_HI) ? LEN_HI : i_frame_len;

  assign w_accept     = r_tvalid & i_m_axis_tready;
  assign w_last_acc   = w_accept & r_tlast;
  assign w_next_beat  = w_accept & ~r_tlast;
  assign w_sent_inc   = r_frames_sent + 32'd1;
  assign w_run_done   = (r_fc != 32'd0) && (w_sent_inc == r_fc);

  assign w_idle_start = (r_state == ST_IDLE) && i_enable &&
                        ((i_frame_count == 32'd0) || (r_frames_sent < i_frame_count));
  assign w_b2b        = (r_state == ST_SEND) && w_last_acc && !w_run_done &&
                        (r_ifg == 8'd0) && i_enable;
  assign w_gap_start  = (r_state == ST_GAP) && (r_gap_cnt == 8'd1) && i_enable;
  assign w_start      = w_idle_start | w_b2b | w_gap_start;

  // Sequence number tracks frames_sent as it will read once the start edge lands
  always_comb begin
    w_seq_start = r_frames_sent;
    if (w_idle_start)
      w_seq_start = 32'd0;
    else if (w_b2b)
      w_seq_start = w_sent_inc;
  end

  // On a start edge the builder sees the live inputs so beat 0 is registered at once
  assign w_bld_beat = w_start ? 11'd0       : r_beat + 11'd1;
  assign w_bld_dst  = w_start ? i_dst_mac   : r_dst;
  assign w_bld_src  = w_start ? i_src_mac   : r_src;
  assign w_bld_seq  = w_start ? w_seq_start : r_frames_sent;
  assign w_bld_len  = w_start ? w_len_clamp : r_len;

  eth_gen_beat_builder #(.ETHERTYPE(ETHERTYPE)) u_builder (
    .i_beat    (w_bld_beat),
    .i_dst_mac (w_bld_dst),
    .i_src_mac (w_bld_src),
    .i_seq     (w_bld_seq),
    .i_len     (w_bld_len),
    .o_tdata   (w_tdata),
    .o_tkeep   (w_tkeep),
    .o_tlast   (w_tlast)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_beat        <= '0;
      r_len         <= '0;
      r_ifg         <= '0;
      r_gap_cnt     <= '0;
      r_dst         <= '0;
      r_src         <= '0;
      r_fc          <= '0;
      r_frames_sent <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_tkeep       <= '0;
      r_tdata       <= '0;
    end else begin
      if (w_start || w_next_beat) begin
        r_beat   <= w_bld_beat;
        r_tdata  <= w_tdata;
        r_tkeep  <= w_tkeep;
        r_tlast  <= w_tlast;
        r_tvalid <= 1'b1;
      end else if (w_last_acc) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
        r_tkeep  <= '0;
        r_tdata  <= '0;
      end

      if (w_start) begin
        r_len <= w_len_clamp;
        r_ifg <= i_ifg_cycles;
        r_dst <= i_dst_mac;
        r_src <= i_src_mac;
      end

      if (w_idle_start) begin
        r_fc          <= i_frame_count;
        r_frames_sent <= '0;
      end else if (w_last_acc) begin
        r_frames_sent <= w_sent_inc;
      end

      case (r_state)
        ST_IDLE: if (w_idle_start) r_state <= ST_SEND;
        ST_SEND: begin
          if (w_last_acc) begin
            if (w_run_done) begin
              r_state <= ST_DONE;
            end else if (r_ifg != 8'd0) begin
              r_state   <= ST_GAP;
              r_gap_cnt <= r_ifg;
            end else if (!i_enable) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 8'd1)
            r_state <= i_enable ? ST_SEND : ST_IDLE;
          else
            r_gap_cnt <= r_gap_cnt - 8'd1;
        end
        ST_DONE: if (!i_enable) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_m_axis_tvalid = r_tvalid;
  assign o_m_axis_tdata  = r_tdata;
  assign o_m_axis_tkeep  = r_tkeep;
  assign o_m_axis_tlast  = r_tlast;
  assign o_m_axis_tuser  = 1'b0;
  assign o_busy          = (r_state == ST_SEND) || (r_state == ST_GAP);
  assign o_done          = (r_state == ST_DONE);
  assign o_frames_sent   = r_frames_sent;

endmodule

// File: doc/eth_frame_gen.md
ETH_FRAME_GEN -- requirements
Module: eth_frame_gen

Interface
REQ-001 Parameter MIN_LEN, default 60, minimum frame length in bytes excluding FCS.
REQ-002 Parameter MAX_LEN, default 9600, maximum frame length in bytes excluding FCS.
REQ-003 Parameter ETHERTYPE, default 16'h88B5, EtherType placed in bytes 12-13.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 enable  in  1  run request; level-sensitive.
REQ-007 frame_len  in  14  frame length in bytes, excluding FCS.
REQ-008 ifg_cycles  in  8  idle clk cycles between the accepted tlast and the next frame's first tvalid.
REQ-009 frame_count  in  32  frames per run; 0 = continuous.
REQ-010 dst_mac / src_mac  in  48 each  header addresses.
REQ-011 m_axis_tvalid/tready/tdata[63:0]/tkeep[7:0]/tlast/tuser[0:0]  out/in/out/out/out/out  AXI-Stream master toward the MAC s_axis_tx port.
REQ-012 busy  out  1  high in SEND or GAP.
REQ-013 done  out  1  finite run complete.
REQ-014 frames_sent  out  32  count of frames with accepted tlast.

Function
REQ-015 Byte n of the frame SHALL sit in lane n%8 of beat n/8, with lane k at tdata[8k+7:8k].
REQ-016 Bytes 0-5 SHALL be dst_mac and bytes 6-11 src_mac, both MSB first; bytes 12-13 ETHERTYPE, MSB first.
REQ-017 Bytes 14-17 SHALL be the 32-bit sequence number, MSB first; the sequence number equals frames_sent at frame start.
REQ-018 Byte n>=18 SHALL be n[7:0].
REQ-019 The effective length L SHALL be frame_len clamped to [MIN_LEN, MAX_LEN] and latched at frame start; frame_len, ifg_cycles, dst_mac and src_mac are latched at frame start.
REQ-020 A frame SHALL be ceil(L/8) beats long; tkeep is 8'hFF on every beat except the last, where it is 8'hFF if L%8==0, else (1<<(L%8))-1; tlast is asserted only on the last beat; tuser is always 0.
REQ-021 States SHALL be IDLE, SEND, GAP and DONE.
REQ-022 IDLE->SEND when enable=1 and (frame_count==0 or frames_sent<frame_count); frame_count is latched on this transition, and frames_sent is cleared on this transition.
REQ-023 First tvalid SHALL assert on the cycle after the IDLE->SEND transition edge (1-cycle latency).
REQ-024 Once tvalid is high, tdata, tkeep and tlast SHALL hold until tready=1; the beat advances only on tvalid&tready.
REQ-025 Accepting the tlast beat SHALL increment frames_sent, modulo 2^32.
REQ-026 After the tlast beat: if the finite run is complete, go to DONE; else if ifg_cycles>0, go to GAP; else if enable=1, start the next frame back-to-back with tvalid staying high; else go to IDLE.
REQ-027 GAP SHALL hold tvalid=0 for exactly the latched ifg_cycles; it then goes to SEND if enable=1, else to IDLE.
REQ-028 Deasserting enable mid-frame SHALL NOT truncate the frame; the current frame completes, then the FSM returns to IDLE.
REQ-029 DONE SHALL hold done=1, tvalid=0; DONE->IDLE when enable=0; done clears on that edge.
REQ-030 tready held low indefinitely SHALL stall without data change or loss; tready high outside tvalid has no effect.

Reset
REQ-031 On rst_n=0 sampled at a clk edge, the block SHALL enter IDLE with tvalid=0, tlast=0, tkeep=0, tdata=0, busy=0, done=0 and frames_sent=0.
REQ-032 Reset mid-frame SHALL abandon the frame immediately with no tlast; the downstream MAC tolerates this only under a full system reset.

Structure
REQ-033 Package eth_gen_pkg SHALL hold the state enum, the MIN_LEN/MAX_LEN defaults, the ETHERTYPE default, the header byte offsets and a keep-mask function.
REQ-034 Sub-module eth_gen_beat_builder SHALL map (beat index, latched MACs, sequence number, L) to tdata/tkeep/tlast as a combinational block; the top module owns the FSM, counters and output registers.

Verification
REQ-035 frame_len=60, frame_count=1, ifg=0, tready=1 -> 8 beats, last tkeep=8'h0F, seq=0, frames_sent=1, done=1.
REQ-036 frame_len=64, frame_count=3, ifg=4 -> three 8-beat frames, last tkeep=8'hFF, exactly 4 idle cycles between frames, seq 0,1,2.
REQ-037 frame_len=10 -> clamped to 60 (8 beats); frame_len=12000 -> clamped to 9600 (1200 beats).
REQ-038 Random tready (50%), frame_len=1500, continuous -> scoreboard byte-exact vs. REQ-015..020; outputs stable while stalled; dropping enable mid-frame yields a complete frame, then IDLE.
REQ-039 rst_n=0 at beat 3 of a 100-byte frame -> next cycle tvalid=0, frames_sent=0, state IDLE; a restart emits seq=0.
